// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the load/store memory access controller.
// Pure definitions: no state and no timing of its own.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_LOAD_WAIT = 2'b01;
  localparam logic [1:0] ST_RMW_READ  = 2'b10;
  localparam logic [1:0] ST_RMW_WRITE = 2'b11;

  // Size 2'b11 decodes as a word, hence the >= compare.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size >= SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (size == SZ_HALF) begin
      if (off[1]) m[31:16] = wd;
      else        m[15:0]  = wd;
    end else begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_extract.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
// Purely combinational; no flow control.
module lane_extract
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Core-to-data-memory access controller: loads take 2 cycles, sub-word stores 3 (read-modify-write),
// aligned word stores 1; stall holds the core while an operation is in flight, misaligned requests are rejected.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;

  logic              stall_c, rvld_c, mis_c, we_c;
  logic [31:0]       wdata_c, ext_rdata;
  logic [ADDR_W-1:0] maddr_c;

  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  lane_extract u_lane_extract (
    .word        (mem_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    stall_c = 1'b0;
    rvld_c  = 1'b0;
    mis_c   = 1'b0;
    we_c    = 1'b0;
    wdata_c = '0;
    maddr_c = addr_q[ADDR_W+1:2];
    case (state_q)
      ST_IDLE: begin
        maddr_c = req_addr[ADDR_W+1:2];
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            mis_c = 1'b1;
          end else if (req_write && req_size[1]) begin
            we_c    = 1'b1;
            wdata_c = req_wdata;
          end else begin
            // Everything else needs a memory read first, so the request is captured here.
            stall_c = 1'b1;
            addr_d  = req_addr[ADDR_W+1:0];
            size_d  = req_size;
            uns_d   = req_unsigned;
            wdata_d = req_wdata[15:0];
            state_d = req_write ? ST_RMW_READ : ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        rvld_c  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RMW_READ: begin
        stall_c = 1'b1;
        merge_d = merge_lane(mem_rdata, addr_q[1:0], size_q, wdata_q);
        state_d = ST_RMW_WRITE;
      end
      default: begin
        we_c    = 1'b1;
        wdata_c = merge_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
    end
  end

  // Gating by rst_n keeps a write from escaping in the cycle reset lands mid-operation.
  assign stall       = rst_n & stall_c;
  assign rdata_valid = rst_n & rvld_c;
  assign rdata       = (rst_n && rvld_c) ? ext_rdata : '0;
  assign misalign    = rst_n & mis_c;
  assign mem_we      = rst_n & we_c;
  assign mem_wdata   = (rst_n && we_c) ? wdata_c : '0;
  assign mem_addr    = rst_n ? maddr_c : '0;

endmodule
